gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
Response-side counterpart to the gate stimulus benches. It receives applied input vectors {a,b} plus the DUT's NAND/NOR outputs, waits a programmable settle time, and compares the outputs against a golden model. It tracks coverage of all four input combinations, counts mismatches and captures the first failing vector. It asserts done/pass once every combination has been checked. It is synthesizable, so the same checker serves iverilog benches and on-board self-test.

Parameters:
SETTLE_CYCLES, 2, clk cycles between latching a vector and sampling DUT outputs (0 allowed)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse: clear statistics, begin a session
sample_valid  input  1  a/b hold a newly applied vector this cycle
a  input  1  applied stimulus A
b  input  1  applied stimulus B
y_nand  input  1  DUT NAND output
y_nor  input  1  DUT NOR output
busy  output  1  high in SETTLE or CHECK
done  output  1  all four combinations checked
pass  output  1  done and err_count==0
err_count  output  ERR_W  mismatch count, saturating
cov_map  output  4  bit {a,b} set once that combination is checked
fail_valid  output  1  a first failure has been captured
fail_vec  output  4  {a,b,y_nand,y_nor} of first failure

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; busy, done, pass, fail_valid = 0; err_count, cov_map, fail_vec = 0; settle counter = 0. Reset wins over every other input. Reset mid-SETTLE/CHECK abandons the check with no statistic update.
- States: IDLE, ARMED, SETTLE, CHECK, DONE.
- IDLE: start -> ARMED. Other inputs ignored.
- start in any non-IDLE state clears err_count, cov_map, fail_valid, fail_vec, done and pass, then goes to ARMED. An in-flight check is discarded.
- ARMED: sample_valid=1 at edge t latches a,b into la,lb.
  - SETTLE_CYCLES>0: go to SETTLE, counter = SETTLE_CYCLES-1.
  - SETTLE_CYCLES=0: go directly to CHECK.
- SETTLE: counter decrements each cycle. At 0, go to CHECK.
- sample_valid outside ARMED is ignored (no queueing). The bench must not pulse it while busy.
- CHECK (one cycle): expected nand = ~(la&lb), expected nor = ~(la|lb). The DUT outputs are sampled this cycle.
  - Mismatch: any bit differs, or any DUT bit is X/Z (case inequality).
  - On mismatch: err_count++ (holds at all-ones). If fail_valid=0, set fail_valid=1 and fail_vec={la,lb,y_nand,y_nor}.
  - Always set cov_map[{la,lb}].
  - Next state is DONE if the updated cov_map==4'hF, else ARMED.
- Latency: vector latched at edge t; statistics update at edge t+SETTLE_CYCLES+1. With the default, the update lands at edge t+3.
- DONE: done=1, pass=(err_count==0), both registered. Stays in DONE until start or reset. sample_valid is ignored.
- Repeated combinations are checked and counted again; cov_map is unaffected.
- busy=1 exactly in SETTLE and CHECK.

Decomposition:
- Shared package/header gate_chk_pkg holds:
  - state encoding (3-bit localparams IDLE..DONE)
  - NUM_COMBOS=4
  - fail_vec field offsets
- Sub-module gate_golden_model: purely combinational. Inputs a,b; outputs exp_nand, exp_nor. It is reused by the future AND/OR/XOR checkers.
- Top holds the FSM, settle counter and statistics registers.

Test Plan:
1. Correct DUT, start then vectors 00,01,10,11 spaced 4 cycles, SETTLE_CYCLES=2 -> after last check: cov_map=4'hF, err_count=0, done=1, pass=1, fail_valid=0.
2. y_nand stuck-at-0, same sequence -> err_count=3 (00,01,10 fail), fail_vec=4'b0001, done=1, pass=0.
3. Vector 00 applied five times -> cov_map=4'b0001, err_count=0, done=0. Then 01,10,11 -> done=1.
4. ERR_W=2, y_nor stuck-at-1 (with y_nand also stuck-at-0), 8 vectors -> err_count saturates at 3 and does not wrap. Second start -> err_count=0, cov_map=0, fail_valid=0.
5. rst_n=0 in SETTLE (edge t+1) -> next cycle all outputs 0, state IDLE, cov_map unchanged from 0. Vectors are ignored until start.
6. SETTLE_CYCLES=0, sample_valid at edge t -> cov_map bit set at edge t+1. sample_valid asserted during SETTLE (default param) is ignored, and cov_map reflects only the latched vector.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checkers: FSM encoding,
// combination count and field layout of the captured failure vector.
package gate_chk_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARMED  = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_CHECK  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam int NUM_COMBOS = 4;

   // fail_vec layout: {a, b, y_nand, y_nor}
   localparam int FV_W    = 4;
   localparam int FV_A    = 3;
   localparam int FV_B    = 2;
   localparam int FV_NAND = 1;
   localparam int FV_NOR  = 0;

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference for two-input NAND/NOR; shared by the gate checkers.
module gate_golden_model (
   input  logic a,
   input  logic b,
   output logic exp_nand,
   output logic exp_nor
);

   assign exp_nand = ~(a & b);
   assign exp_nor  = ~(a | b);

endmodule

// File: rtl/gate_response_checker.sv
// Latches applied {a,b} vectors, waits SETTLE_CYCLES, then compares DUT NAND/NOR
// outputs against the golden model while tracking coverage and errors.
module gate_response_checker
   import gate_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sample_valid,
   input  logic                  a,
   input  logic                  b,
   input  logic                  y_nand,
   input  logic                  y_nor,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_count,
   output logic [NUM_COMBOS-1:0] cov_map,
   output logic                  fail_valid,
   output logic [FV_W-1:0]       fail_vec
);

   localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

   logic [2:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  la_q, la_d, lb_q, lb_d;
   logic [ERR_W-1:0]      err_q, err_d;
   logic [NUM_COMBOS-1:0] cov_q, cov_d;
   logic                  fv_q, fv_d;
   logic [FV_W-1:0]       fvec_q, fvec_d;
   logic                  done_q, done_d, pass_q, pass_d;

   logic                  exp_nand, exp_nor;
   logic                  mismatch;
   logic [ERR_W-1:0]      err_upd;
   logic [NUM_COMBOS-1:0] cov_upd;

   gate_golden_model u_golden (
      .a        (la_q),
      .b        (lb_q),
      .exp_nand (exp_nand),
      .exp_nor  (exp_nor)
   );

   // Case inequality so X/Z on a DUT output counts as a mismatch in simulation.
   assign mismatch = (y_nand !== exp_nand) || (y_nor !== exp_nor);
   assign err_upd  = (mismatch && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
   assign cov_upd  = cov_q | (NUM_COMBOS'(1) << {la_q, lb_q});

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      la_d    = la_q;
      lb_d    = lb_q;
      err_d   = err_q;
      cov_d   = cov_q;
      fv_d    = fv_q;
      fvec_d  = fvec_q;
      done_d  = done_q;
      pass_d  = pass_q;
      if (start) begin
         state_d = ST_ARMED;
         err_d   = '0;
         cov_d   = '0;
         fv_d    = 1'b0;
         fvec_d  = '0;
         done_d  = 1'b0;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (sample_valid) begin
                  la_d = a;
                  lb_d = b;
                  if (SETTLE_CYCLES > 0) begin
                     state_d = ST_SETTLE;
                     cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                  end else begin
                     state_d = ST_CHECK;
                  end
               end
            end
            ST_SETTLE: begin
               if (cnt_q == '0) state_d = ST_CHECK;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_CHECK: begin
               err_d = err_upd;
               cov_d = cov_upd;
               if (mismatch && !fv_q) begin
                  fv_d            = 1'b1;
                  fvec_d[FV_A]    = la_q;
                  fvec_d[FV_B]    = lb_q;
                  fvec_d[FV_NAND] = y_nand;
                  fvec_d[FV_NOR]  = y_nor;
               end
               if (cov_upd == '1) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  pass_d  = (err_upd == '0);
               end else begin
                  state_d = ST_ARMED;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         la_q    <= 1'b0;
         lb_q    <= 1'b0;
         err_q   <= '0;
         cov_q   <= '0;
         fv_q    <= 1'b0;
         fvec_q  <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         la_q    <= la_d;
         lb_q    <= lb_d;
         err_q   <= err_d;
         cov_q   <= cov_d;
         fv_q    <= fv_d;
         fvec_q  <= fvec_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign busy       = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign cov_map    = cov_q;
   assign fail_valid = fv_q;
   assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: three parameterisations share
// stimulus; a bench-side fault injector drives the NAND/NOR responses.
module tb_gate_response_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, sample_valid, a, b;
   logic f_nand0, f_nor1;
   logic y_nand, y_nor;

   assign y_nand = f_nand0 ? 1'b0 : ~(a & b);
   assign y_nor  = f_nor1  ? 1'b1 : ~(a | b);

   logic       busy0, done0, pass0, fv0;
   logic [7:0] err0;
   logic [3:0] cov0, fvec0;
   logic       busy1, done1, pass1, fv1;
   logic [1:0] err1;
   logic [3:0] cov1, fvec1;
   logic       busy2, done2, pass2, fv2;
   logic [7:0] err2;
   logic [3:0] cov2, fvec2;

   gate_response_checker #(.SETTLE_CYCLES(2), .ERR_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
      .a(a), .b(b), .y_nand(y_nand), .y_nor(y_nor),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .cov_map(cov0), .fail_valid(fv0), .fail_vec(fvec0));

   gate_response_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
      .a(a), .b(b), .y_nand(y_nand), .y_nor(y_nor),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .cov_map(cov1), .fail_valid(fv1), .fail_vec(fvec1));

   gate_response_checker #(.SETTLE_CYCLES(0), .ERR_W(8)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
      .a(a), .b(b), .y_nand(y_nand), .y_nor(y_nor),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .cov_map(cov2), .fail_valid(fv2), .fail_vec(fvec2));

   typedef struct {
      logic [7:0] err;
      logic [3:0] cov;
      logic       fv;
      logic [3:0] fvec;
      logic       done;
      logic       pass;
      logic       busy;
   } snap_t;

   snap_t sb[$];

   logic [7:0] m_err [3];
   logic [3:0] m_cov [3];
   logic [3:0] m_fvec[3];
   logic       m_fv  [3];
   logic       m_done[3];
   logic       m_pass[3];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic snap_t observe(input int inst);
      snap_t s;
      case (inst)
         0:       s = '{err0, cov0, fv0, fvec0, done0, pass0, busy0};
         1:       s = '{{6'b0, err1}, cov1, fv1, fvec1, done1, pass1, busy1};
         default: s = '{err2, cov2, fv2, fvec2, done2, pass2, busy2};
      endcase
      return s;
   endfunction

   task automatic model_start(input int inst);
      m_err[inst]  = '0;
      m_cov[inst]  = '0;
      m_fvec[inst] = '0;
      m_fv[inst]   = 1'b0;
      m_done[inst] = 1'b0;
      m_pass[inst] = 1'b0;
   endtask

   // Predict the statistics after one checked vector and queue them.
   task automatic model_vec(input int inst, input logic va, input logic vb);
      logic       en, eo, yn, yo;
      logic [7:0] maxv;
      snap_t      s;
      maxv = (inst == 1) ? 8'd3 : 8'd255;
      en = !(va && vb);
      eo = !(va || vb);
      yn = f_nand0 ? 1'b0 : en;
      yo = f_nor1  ? 1'b1 : eo;
      if (!m_done[inst]) begin
         if ((yn != en) || (yo != eo)) begin
            if (m_err[inst] < maxv) m_err[inst] = m_err[inst] + 8'd1;
            if (!m_fv[inst]) begin
               m_fv[inst]   = 1'b1;
               m_fvec[inst] = {va, vb, yn, yo};
            end
         end
         m_cov[inst][{va, vb}] = 1'b1;
         if (m_cov[inst] == 4'hF) begin
            m_done[inst] = 1'b1;
            m_pass[inst] = (m_err[inst] == 8'd0);
         end
      end
      s = '{m_err[inst], m_cov[inst], m_fv[inst], m_fvec[inst], m_done[inst], m_pass[inst], 1'b0};
      sb.push_back(s);
   endtask

   task automatic compare_snap(input int inst, input string tag);
      snap_t e, o;
      if (sb.size() == 0) begin
         check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      o = observe(inst);
      check_eq({tag, ".err"},  32'(o.err),  32'(e.err));
      check_eq({tag, ".cov"},  32'(o.cov),  32'(e.cov));
      check_eq({tag, ".fv"},   32'(o.fv),   32'(e.fv));
      check_eq({tag, ".fvec"}, 32'(o.fvec), 32'(e.fvec));
      check_eq({tag, ".done"}, 32'(o.done), 32'(e.done));
      check_eq({tag, ".pass"}, 32'(o.pass), 32'(e.pass));
      check_eq({tag, ".busy"}, 32'(o.busy), 32'(e.busy));
   endtask

   task automatic send_vec(input int inst, input logic va, input logic vb, input int settle,
                           input string tag);
      snap_t o;
      @(negedge clk);
      a = va; b = vb; sample_valid = 1'b1;
      model_vec(inst, va, vb);
      @(negedge clk);
      sample_valid = 1'b0;
      o = observe(inst);
      if (settle > 0 && !m_done[inst]) check_eq({tag, ".busy_settle"}, 32'(o.busy), 32'd1);
      repeat (settle + 1) @(negedge clk);
      compare_snap(inst, tag);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) model_start(i);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      snap_t o;
      rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0; a = 1'b0; b = 1'b0;
      f_nand0 = 1'b0; f_nor1 = 1'b0;
      for (int i = 0; i < 3; i++) model_start(i);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{8'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
         compare_snap(i, $sformatf("reset.u%0d", i));
      end
      rst_n = 1'b1;

      // Correct DUT, full coverage
      pulse_start();
      for (int v = 0; v < 4; v++) send_vec(0, v[1], v[0], 2, $sformatf("t1.v%0d", v));

      // NAND stuck at 0
      f_nand0 = 1'b1;
      pulse_start();
      for (int v = 0; v < 4; v++) send_vec(0, v[1], v[0], 2, $sformatf("t2.v%0d", v));
      f_nand0 = 1'b0;

      // Repeated combination does not complete coverage
      pulse_start();
      for (int k = 0; k < 5; k++) send_vec(0, 1'b0, 1'b0, 2, $sformatf("t3.rep%0d", k));
      for (int v = 1; v < 4; v++) send_vec(0, v[1], v[0], 2, $sformatf("t3.v%0d", v));

      // Saturating 2-bit error counter, then restart clears statistics
      f_nand0 = 1'b1; f_nor1 = 1'b1;
      pulse_start();
      for (int k = 0; k < 8; k++) send_vec(1, 1'(k % 3 == 2), 1'(k % 3 == 1), 2, $sformatf("t4.k%0d", k));
      f_nand0 = 1'b0; f_nor1 = 1'b0;
      pulse_start();
      @(negedge clk);
      sb.push_back('{8'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
      compare_snap(1, "t4.restart");

      // Reset during SETTLE abandons the check; vectors ignored until start
      pulse_start();
      send_vec(0, 1'b0, 1'b0, 2, "t5.pre");
      @(negedge clk);
      a = 1'b0; b = 1'b1; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      check_eq("t5.busy_before_reset", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_start(0);
      sb.push_back('{8'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
      compare_snap(0, "t5.after_reset");
      @(negedge clk);
      a = 1'b1; b = 1'b1; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (4) @(negedge clk);
      sb.push_back('{8'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
      compare_snap(0, "t5.idle_ignores");

      // Zero settle: update one edge after the latch
      pulse_start();
      @(negedge clk);
      a = 1'b1; b = 1'b0; sample_valid = 1'b1;
      model_vec(2, 1'b1, 1'b0);
      @(negedge clk);
      sample_valid = 1'b0;
      check_eq("t6a.cov_before", 32'(cov2), 32'd0);
      @(negedge clk);
      compare_snap(2, "t6a.after");

      // sample_valid during SETTLE is ignored
      pulse_start();
      @(negedge clk);
      a = 1'b1; b = 1'b1; sample_valid = 1'b1;
      model_vec(0, 1'b1, 1'b1);
      @(negedge clk);
      a = 1'b0; b = 1'b0;
      @(negedge clk);
      a = 1'b1; b = 1'b1; sample_valid = 1'b0;
      repeat (2) @(negedge clk);
      compare_snap(0, "t6b.settle_ignore");
      o = observe(0);
      check_eq("t6b.cov_only_11", 32'(o.cov), 32'h8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
